// File: rtl/nand_bus_phy.sv
// Pin-level NAND bus timing engine: one CMD/ADDR/WDATA/RDATA byte per request,
// with counter-timed setup / strobe-low / strobe-high phases and registered pins.
module nand_bus_phy #(
  parameter int T_SETUP = 1,
  parameter int T_LOW   = 2,
  parameter int T_HIGH  = 2
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_type,
  input  logic [7:0] req_data,
  input  logic       req_last,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       wp_en,
  input  logic       R_B,
  output logic       rb_ready,
  output logic       nCE,
  output logic       CLE,
  output logic       ALE,
  output logic       nWE,
  output logic       nRE,
  output logic       nWP,
  output logic [7:0] IO_out,
  output logic       IO_oe,
  input  logic [7:0] IO_in
);

  localparam logic [1:0] TYP_CMD   = 2'd0;
  localparam logic [1:0] TYP_ADDR  = 2'd1;
  localparam logic [1:0] TYP_RDATA = 2'd3;

  // Counters count down to 0, so a phase of N cycles loads N-1; 0 behaves as 1.
  localparam logic [3:0] LD_S = (T_SETUP <= 1) ? 4'd0 : 4'(T_SETUP - 1);
  localparam logic [3:0] LD_L = (T_LOW   <= 1) ? 4'd0 : 4'(T_LOW   - 1);
  localparam logic [3:0] LD_H = (T_HIGH  <= 1) ? 4'd0 : 4'(T_HIGH  - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH} state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [1:0] type_q;
  logic       last_q;
  logic       nce_q, cle_q, ale_q, nwe_q, nre_q, nwp_q, oe_q;
  logic [7:0] out_q, rspd_q;
  logic       rspv_q;
  logic       rb_s1_q, rb_s2_q;

  assign req_ready = (state_q == S_IDLE) && !PRESET;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      type_q  <= 2'd0;
      last_q  <= 1'b0;
      nce_q   <= 1'b1;
      cle_q   <= 1'b0;
      ale_q   <= 1'b0;
      nwe_q   <= 1'b1;
      nre_q   <= 1'b1;
      nwp_q   <= 1'b0;
      oe_q    <= 1'b0;
      out_q   <= 8'd0;
      rspv_q  <= 1'b0;
      rspd_q  <= 8'd0;
      rb_s1_q <= 1'b0;
      rb_s2_q <= 1'b0;
    end else begin
      nwp_q   <= ~wp_en;
      rb_s1_q <= R_B;
      rb_s2_q <= rb_s1_q;
      rspv_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            type_q  <= req_type;
            last_q  <= req_last;
            out_q   <= req_data;
            nce_q   <= 1'b0;
            cle_q   <= (req_type == TYP_CMD);
            ale_q   <= (req_type == TYP_ADDR);
            oe_q    <= (req_type != TYP_RDATA);
            cnt_q   <= LD_S;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_LOW;
            cnt_q   <= LD_L;
            if (type_q == TYP_RDATA) nre_q <= 1'b0;
            else                     nwe_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_LOW: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_HIGH;
            cnt_q   <= LD_H;
            nwe_q   <= 1'b1;
            nre_q   <= 1'b1;
            // Sampled on the rising edge that releases nRE, while it is still low.
            if (type_q == TYP_RDATA) rspd_q <= IO_in;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_HIGH: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_IDLE;
            cle_q   <= 1'b0;
            ale_q   <= 1'b0;
            oe_q    <= 1'b0;
            rspv_q  <= (type_q == TYP_RDATA);
            if (last_q) nce_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign nCE       = nce_q;
  assign CLE       = cle_q;
  assign ALE       = ale_q;
  assign nWE       = nwe_q;
  assign nRE       = nre_q;
  assign nWP       = nwp_q;
  assign IO_oe     = oe_q;
  assign IO_out    = out_q;
  assign rsp_valid = rspv_q;
  assign rsp_data  = rspd_q;
  assign rb_ready  = rb_s2_q;

endmodule

// File: tb/tb_nand_bus_phy.sv
// Directed bench for nand_bus_phy: per-cycle pin vectors for whole bytes plus
// hand sequences for reset, synchroniser/nWP latency and non-default timing.
module tb_nand_bus_phy;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       rv, rl, wp_en, R_B;
  logic [1:0] rt;
  logic [7:0] rd, io_in;
  logic       req_ready, rsp_valid, rb_ready;
  logic [7:0] rsp_data, IO_out;
  logic       nCE, CLE, ALE, nWE, nRE, nWP, IO_oe;

  logic       v2, l2;
  logic [1:0] t2;
  logic [7:0] d2;
  logic       rdy2, rspv2, rbr2;
  logic [7:0] rspd2, out2;
  logic       nce2, cle2, ale2, nwe2, nre2, nwp2, oe2;

  always #5 PCLK = ~PCLK;

  nand_bus_phy u0 (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(rv), .req_ready(req_ready),
    .req_type(rt), .req_data(rd), .req_last(rl), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .wp_en(wp_en), .R_B(R_B), .rb_ready(rb_ready),
    .nCE(nCE), .CLE(CLE), .ALE(ALE), .nWE(nWE), .nRE(nRE), .nWP(nWP),
    .IO_out(IO_out), .IO_oe(IO_oe), .IO_in(io_in)
  );

  nand_bus_phy #(.T_SETUP(3), .T_LOW(4), .T_HIGH(1)) u1 (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(v2), .req_ready(rdy2),
    .req_type(t2), .req_data(d2), .req_last(l2), .rsp_valid(rspv2),
    .rsp_data(rspd2), .wp_en(wp_en), .R_B(R_B), .rb_ready(rbr2),
    .nCE(nce2), .CLE(cle2), .ALE(ale2), .nWE(nwe2), .nRE(nre2), .nWP(nwp2),
    .IO_out(out2), .IO_oe(oe2), .IO_in(8'h00)
  );

  typedef struct {
    logic        v;
    logic [1:0]  t;
    logic [7:0]  d;
    logic        l;
    logic [7:0]  ioin;
    logic [24:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] exp_rd;
  int         checks = 0;
  int         errors = 0;

  // {nCE,CLE,ALE,nWE,nRE,nWP,IO_oe,IO_out,req_ready,rsp_valid,rsp_data}
  function automatic logic [24:0] pk(input logic nce, cle, ale, nwe, nre, nwp, oe,
                                     input logic [7:0] out, input logic rdy, rvl,
                                     input logic [7:0] rdat);
    return {nce, cle, ale, nwe, nre, nwp, oe, out, rdy, rvl, rdat};
  endfunction

  wire [24:0] act = {nCE, CLE, ALE, nWE, nRE, nWP, IO_oe, IO_out, req_ready, rsp_valid, rsp_data};

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Six rows per default-timing byte: k0 SETUP, k1-2 LOW, k3-4 HIGH, k5 IDLE.
  // Rows 1..5 drive the given follow-on request (held valid while not ready).
  task automatic add_byte(input logic [1:0] t, input logic [7:0] d, input logic l,
                          input logic [7:0] ioin, input logic nv, input logic [1:0] nt,
                          input logic [7:0] nd, input logic nl);
    vec_t r;
    logic rdt;
    rdt = (t == 2'd3);
    for (int k = 0; k < 6; k++) begin
      r.v    = (k == 0) ? 1'b1 : nv;
      r.t    = (k == 0) ? t : nt;
      r.d    = (k == 0) ? d : nd;
      r.l    = (k == 0) ? l : nl;
      r.ioin = ioin;
      if (rdt && k == 3) exp_rd = ioin;
      case (k)
        0:       r.exp = pk(0, t == 0, t == 1, 1, 1, 1, !rdt, d, 0, 0, exp_rd);
        1, 2:    r.exp = pk(0, t == 0, t == 1, rdt, !rdt, 1, !rdt, d, 0, 0, exp_rd);
        3, 4:    r.exp = pk(0, t == 0, t == 1, 1, 1, 1, !rdt, d, 0, 0, exp_rd);
        default: r.exp = pk(l, 0, 0, 1, 1, 1, 0, d, 1, rdt, exp_rd);
      endcase
      tbl.push_back(r);
    end
  endtask

  task automatic run_from(input int start);
    for (int i = start; i < tbl.size(); i++) begin
      rv = tbl[i].v; rt = tbl[i].t; rd = tbl[i].d; rl = tbl[i].l; io_in = tbl[i].ioin;
      @(posedge PCLK); #1;
      checks++;
      if (act !== tbl[i].exp) begin
        errors++;
        $display("FAIL row%0d: got %h expected %h", i, act, tbl[i].exp);
      end
    end
    rv = 1'b0; io_in = 8'h00;
  endtask

  int acc_n, acc0, acc1, low_n, start;

  initial begin
    PRESET = 1'b1; rv = 0; rt = 0; rd = 0; rl = 0; wp_en = 0; R_B = 0; io_in = 0;
    v2 = 0; t2 = 0; d2 = 0; l2 = 0;
    exp_rd = 8'h00;

    add_byte(2'd0, 8'h70, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
    add_byte(2'd1, 8'h12, 1'b0, 8'h00, 1'b1, 2'd1, 8'h34, 1'b0);
    add_byte(2'd1, 8'h34, 1'b0, 8'h00, 1'b1, 2'd1, 8'h56, 1'b1);
    add_byte(2'd1, 8'h56, 1'b1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
    add_byte(2'd2, 8'h9C, 1'b1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
    add_byte(2'd3, 8'h00, 1'b1, 8'hA5, 1'b0, 2'd0, 8'h00, 1'b0);

    repeat (2) @(posedge PCLK);
    #1;
    chk("reset_pins", 32'(act), 32'(pk(1, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00)));
    chk("reset_rb", 32'(rb_ready), 32'd0);
    PRESET = 1'b0;

    run_from(0);

    // R_B synchroniser and nWP latency
    R_B = 1'b1; wp_en = 1'b1;
    @(posedge PCLK); #1;
    chk("rb_1cyc", 32'(rb_ready), 32'd0);
    chk("nwp_fall", 32'(nWP), 32'd0);
    @(posedge PCLK); #1;
    chk("rb_2cyc", 32'(rb_ready), 32'd1);
    wp_en = 1'b0;
    @(posedge PCLK); #1;
    chk("nwp_rise", 32'(nWP), 32'd1);

    // Reset during the second LOW cycle of a WDATA byte
    rv = 1'b1; rt = 2'd2; rd = 8'hFF; rl = 1'b0;
    @(posedge PCLK); #1;
    rv = 1'b0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    chk("midop_nwe_low", 32'(nWE), 32'd0);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    chk("midop_reset", 32'(act), 32'(pk(1, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00)));
    PRESET = 1'b0;
    exp_rd = 8'h00;
    start = tbl.size();
    add_byte(2'd3, 8'h00, 1'b1, 8'h3C, 1'b0, 2'd0, 8'h00, 1'b0);
    run_from(start);
    @(posedge PCLK); #1;
    chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    chk("rsp_hold", 32'(rsp_data), 32'h3C);

    // Non-default timing instance, request held valid continuously
    v2 = 1'b1; t2 = 2'd0; d2 = 8'h55; l2 = 1'b0;
    acc_n = 0; acc0 = 0; acc1 = 0; low_n = 0;
    for (int c = 0; c < 40 && acc_n < 2; c++) begin
      if (acc_n == 1 && !nwe2) low_n++;
      if (v2 && rdy2) begin
        if (acc_n == 0) acc0 = c; else acc1 = c;
        acc_n++;
      end
      @(posedge PCLK); #1;
    end
    v2 = 1'b0;
    chk("slow_accepts", 32'(acc_n), 32'd2);
    chk("slow_spacing", 32'(acc1 - acc0), 32'd9);
    chk("slow_low_cycles", 32'(low_n), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
